// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared encodings for the MIPS pipeline writeback and
//               data-memory paths (writeback source and load/store type).
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Writeback source select (MemToReg); 2'b11 is reserved and behaves as ALU
    typedef logic [1:0] wb_src_t;
    localparam wb_src_t WB_SRC_ALU  = 2'b00;
    localparam wb_src_t WB_SRC_MEM  = 2'b01;
    localparam wb_src_t WB_SRC_LINK = 2'b10;

    // Load/store access type; unlisted codes behave as a full word
    typedef logic [2:0] ld_type_t;
    localparam ld_type_t LD_W  = 3'b000;
    localparam ld_type_t LD_B  = 3'b001;
    localparam ld_type_t LD_BU = 3'b010;
    localparam ld_type_t LD_H  = 3'b011;
    localparam ld_type_t LD_HU = 3'b100;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage_if
// Description : MEM->WB pipeline bundle plus the register-file write port.
//               master = MEM-stage / pipeline control side,
//               slave  = writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface writeback_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // pipeline control
    logic              Stall;
    logic              Flush;
    // MEM-stage results
    logic              MemValid;
    logic              MemRegWrite;
    logic [ADDR_W-1:0] MemWriteAddress;
    logic [1:0]        MemToReg;
    logic [2:0]        MemLoadType;
    logic [1:0]        MemByteOffset;
    logic [DATA_W-1:0] MemAluResult;
    logic [DATA_W-1:0] MemReadData;
    logic [DATA_W-1:0] MemLinkPC;
    // register-file write port and status
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteAddress;
    logic [DATA_W-1:0] WriteData;
    logic              WbValid;
    logic [31:0]       InstrRetired;

    modport master (
        output Stall, Flush, MemValid, MemRegWrite, MemWriteAddress, MemToReg,
               MemLoadType, MemByteOffset, MemAluResult, MemReadData, MemLinkPC,
        input  RegWrite, WriteAddress, WriteData, WbValid, InstrRetired
    );

    modport slave (
        input  Stall, Flush, MemValid, MemRegWrite, MemWriteAddress, MemToReg,
               MemLoadType, MemByteOffset, MemAluResult, MemReadData, MemLinkPC,
        output RegWrite, WriteAddress, WriteData, WbValid, InstrRetired
    );
endinterface : writeback_stage_if
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Big-endian sub-word extraction and sign/zero extension of a
//               32-bit data-memory word. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import mips_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [2:0]  load_type,
    input  logic [1:0]  byte_offset,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select: offset 0 is the most significant byte (big-endian);
    // halfwords look only at offset[1], so misaligned halves just round down.
    always_comb begin
        byte_sel = raw_word[31:24];
        case (byte_offset)
            2'd0:    byte_sel = raw_word[31:24];
            2'd1:    byte_sel = raw_word[23:16];
            2'd2:    byte_sel = raw_word[15:8];
            default: byte_sel = raw_word[7:0];
        endcase
        half_sel = byte_offset[1] ? raw_word[15:0] : raw_word[31:16];
    end

    // Extension by access type; unknown codes fall back to a word load
    always_comb begin
        ext_data = raw_word;
        case (load_type)
            LD_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   ext_data = {24'h0, byte_sel};
            LD_H:    ext_data = {{16{half_sel[15]}}, half_sel};
            LD_HU:   ext_data = {16'h0, half_sel};
            default: ext_data = raw_word;
        endcase
    end

endmodule : load_extend
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : MEM/WB pipeline register and writeback datapath. Drives the
//               register-file write port, suppresses R0 writes and counts
//               retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  bus
);

    logic              wb_valid;
    logic              wb_reg_write;
    logic [ADDR_W-1:0] wb_addr;
    wb_src_t           wb_to_reg;
    ld_type_t          wb_load_type;
    logic [1:0]        wb_byte_offset;
    logic [DATA_W-1:0] wb_alu_result;
    logic [DATA_W-1:0] wb_read_data;
    logic [DATA_W-1:0] wb_link_pc;
    logic [31:0]       retired_count;

    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] write_data;

    // MEM/WB register: Flush beats Stall beats capture. The counter retires
    // the instruction leaving WB on any unstalled edge, so a stalled
    // instruction counts once and a flushed-out valid one still counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_addr        <= '0;
            wb_to_reg      <= WB_SRC_ALU;
            wb_load_type   <= LD_W;
            wb_byte_offset <= 2'b00;
            wb_alu_result  <= '0;
            wb_read_data   <= '0;
            wb_link_pc     <= '0;
            retired_count  <= 32'h0;
        end else begin
            if (wb_valid && !bus.Stall) begin
                retired_count <= retired_count + 32'd1;
            end
            if (bus.Flush) begin
                wb_valid <= 1'b0;
            end else if (!bus.Stall) begin
                wb_valid       <= bus.MemValid;
                wb_reg_write   <= bus.MemRegWrite;
                wb_addr        <= bus.MemWriteAddress;
                wb_to_reg      <= bus.MemToReg;
                wb_load_type   <= bus.MemLoadType;
                wb_byte_offset <= bus.MemByteOffset;
                wb_alu_result  <= bus.MemAluResult;
                wb_read_data   <= bus.MemReadData;
                wb_link_pc     <= bus.MemLinkPC;
            end
        end
    end

    load_extend u_load_extend (
        .raw_word    (wb_read_data),
        .load_type   (wb_load_type),
        .byte_offset (wb_byte_offset),
        .ext_data    (load_data)
    );

    // Writeback source mux; a bubble always presents zero data
    always_comb begin
        write_data = '0;
        if (wb_valid) begin
            case (wb_to_reg)
                WB_SRC_MEM:  write_data = load_data;
                WB_SRC_LINK: write_data = wb_link_pc;
                default:     write_data = wb_alu_result;
            endcase
        end
    end

    assign bus.RegWrite     = wb_valid && wb_reg_write && (wb_addr != '0);
    assign bus.WriteAddress = wb_addr;
    assign bus.WriteData    = write_data;
    assign bus.WbValid      = wb_valid;
    assign bus.InstrRetired = retired_count;

endmodule : writeback_stage
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Scoreboard bench for writeback_stage: a driver updates an
//               architectural model and queues the expected WB view; a
//               monitor compares after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    writeback_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    writeback_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        reg_write;
        logic        valid;
        logic        chk_addr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int checks_total = 0;
    int checks_pass  = 0;

    // architectural model of what sits in WB
    logic        m_valid = 1'b0;
    logic        m_wr    = 1'b0;
    logic [4:0]  m_addr  = 5'd0;
    logic [31:0] m_data  = 32'h0;
    logic [31:0] m_cnt   = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Loaded value from the memory rules: big-endian lanes, halves by offset[1]
    function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [1:0] off,
                                               input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        b  = (rd >> (8 * (3 - int'(off)))) & 32'hFF;
        h  = off[1] ? (rd & 32'hFFFF) : (rd >> 16);
        sb = b[7:0];
        sh = h[15:0];
        case (lt)
            3'd1:    return 32'(sb);
            3'd2:    return b;
            3'd3:    return 32'(sh);
            3'd4:    return h;
            default: return rd;
        endcase
    endfunction

    // One cycle of stimulus: drive at the falling edge, advance the model to
    // the state expected after the next rising edge, queue the expectation.
    task automatic step(input bit rst_v, input bit stall, input bit flush, input bit mv,
                        input bit mw, input logic [4:0] a, input logic [1:0] tr,
                        input logic [2:0] lt, input logic [1:0] off, input logic [31:0] alu,
                        input logic [31:0] rd, input logic [31:0] lk, input bit dep);
        exp_t e;
        @(negedge clk);
        if (dep) begin
            force dut.retired_count = 32'hFFFF_FFFF;
            release dut.retired_count;
            m_cnt = 32'hFFFF_FFFF;
        end
        rst                 = rst_v;
        bus.Stall           = stall;
        bus.Flush           = flush;
        bus.MemValid        = mv;
        bus.MemRegWrite     = mw;
        bus.MemWriteAddress = a;
        bus.MemToReg        = tr;
        bus.MemLoadType     = lt;
        bus.MemByteOffset   = off;
        bus.MemAluResult    = alu;
        bus.MemReadData     = rd;
        bus.MemLinkPC       = lk;
        if (!rst_v) begin
            m_valid = 1'b0; m_wr = 1'b0; m_addr = 5'd0; m_data = 32'h0; m_cnt = 32'h0;
        end else begin
            if (m_valid && !stall) m_cnt = m_cnt + 32'd1;
            if (flush) m_valid = 1'b0;
            else if (!stall) begin
                m_valid = mv;
                m_wr    = mw;
                m_addr  = a;
                m_data  = (tr == 2'b01) ? model_load(lt, off, rd) : (tr == 2'b10) ? lk : alu;
            end
        end
        e.reg_write = m_valid && m_wr && (m_addr != 5'd0);
        e.valid     = m_valid;
        e.chk_addr  = m_valid || !rst_v;
        e.addr      = m_addr;
        e.data      = m_valid ? m_data : 32'h0;
        e.cnt       = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic step_rand();
        step(1'b1, ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 5) != 0), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
             2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             $urandom, $urandom, $urandom, 1'b0);
    endtask

    // Monitor: compare every presented WB state against the queued model view
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("RegWrite", 32'(bus.RegWrite), 32'(e.reg_write));
                check("WbValid", 32'(bus.WbValid), 32'(e.valid));
                check("WriteData", bus.WriteData, e.data);
                check("InstrRetired", bus.InstrRetired, e.cnt);
                if (e.chk_addr) check("WriteAddress", 32'(bus.WriteAddress), 32'(e.addr));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] RD = 32'h80F2_7F01;

    initial begin
        rst = 1'b0;
        bus.Stall = 1'b0; bus.Flush = 1'b0; bus.MemValid = 1'b0; bus.MemRegWrite = 1'b0;
        bus.MemWriteAddress = 5'd0; bus.MemToReg = 2'b00; bus.MemLoadType = 3'b000;
        bus.MemByteOffset = 2'b00; bus.MemAluResult = 32'h0; bus.MemReadData = 32'h0;
        bus.MemLinkPC = 32'h0;

        // reset held with a live instruction on the inputs
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 2'b00, 3'd0, 2'd0, 32'h1111_2222, RD, 32'h0, 1'b0);

        // ALU writeback, then the counter follows on the next edge
        step(1'b1, 0, 0, 1, 1, 5'd5, 2'b00, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 0);
        // loads from 0x80F27F01
        step(1'b1, 0, 0, 1, 1, 5'd1, 2'b01, 3'd1, 2'd0, 32'h0, RD, 32'h0, 0);
        step(1'b1, 0, 0, 1, 1, 5'd2, 2'b01, 3'd2, 2'd0, 32'h0, RD, 32'h0, 0);
        step(1'b1, 0, 0, 1, 1, 5'd3, 2'b01, 3'd1, 2'd2, 32'h0, RD, 32'h0, 0);
        step(1'b1, 0, 0, 1, 1, 5'd4, 2'b01, 3'd3, 2'd0, 32'h0, RD, 32'h0, 0);
        step(1'b1, 0, 0, 1, 1, 5'd6, 2'b01, 3'd4, 2'd2, 32'h0, RD, 32'h0, 0);
        step(1'b1, 0, 0, 1, 1, 5'd8, 2'b01, 3'd0, 2'd3, 32'h0, RD, 32'h0, 0);
        step(1'b1, 0, 0, 1, 1, 5'd9, 2'b01, 3'd3, 2'd3, 32'h0, RD, 32'h0, 0);
        // R0 suppression, JAL link, reserved source
        step(1'b1, 0, 0, 1, 1, 5'd0, 2'b00, 3'd0, 2'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 0);
        step(1'b1, 0, 0, 1, 1, 5'd31, 2'b10, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0040_0008, 0);
        step(1'b1, 0, 0, 1, 1, 5'd12, 2'b11, 3'd1, 2'd0, 32'hCAFE_F00D, RD, 32'h0, 0);
        // stall three cycles with addr 10 held, then release
        step(1'b1, 0, 0, 1, 1, 5'd10, 2'b00, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 0);
        repeat (3) step(1'b1, 1, 0, 1, 1, 5'd20, 2'b00, 3'd0, 2'd0, 32'hBAD0_BAD0, 32'h0, 32'h0, 0);
        step(1'b1, 0, 0, 1, 1, 5'd11, 2'b00, 3'd0, 2'd0, 32'h0000_0011, 32'h0, 32'h0, 0);
        // flush together with stall inserts a bubble
        step(1'b1, 1, 1, 1, 1, 5'd13, 2'b00, 3'd0, 2'd0, 32'h0000_0013, 32'h0, 32'h0, 0);
        step(1'b1, 0, 0, 1, 1, 5'd14, 2'b00, 3'd0, 2'd0, 32'h0000_0014, 32'h0, 32'h0, 0);
        // counter wrap: deposit all-ones, the valid instruction leaves -> 0
        step(1'b1, 0, 0, 1, 1, 5'd15, 2'b00, 3'd0, 2'd0, 32'h0000_0015, 32'h0, 32'h0, 1);
        step(1'b1, 0, 0, 1, 1, 5'd16, 2'b00, 3'd0, 2'd0, 32'h0000_0016, 32'h0, 32'h0, 0);

        // asynchronous reset mid-cycle with a valid write in WB
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async RegWrite", 32'(bus.RegWrite), 32'h0);
        check("async WbValid", 32'(bus.WbValid), 32'h0);
        check("async WriteData", bus.WriteData, 32'h0);
        check("async InstrRetired", bus.InstrRetired, 32'h0);
        step(1'b0, 0, 0, 1, 1, 5'd17, 2'b00, 3'd0, 2'd0, 32'h0000_0017, 32'h0, 32'h0, 0);

        // randomized traffic
        repeat (400) step_rand();
        step(1'b1, 0, 0, 0, 0, 5'd0, 2'b00, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 0);

        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule : tb_writeback_stage
`default_nettype wire

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback datapath for the MIPS pipeline.
- It is the write side of register_file: it drives RegWrite, WriteAddress and WriteData from MEM-stage results.
- It extracts and extends sub-word load data, selects the writeback source, and suppresses writes to R0.
- It exports a retired-instruction counter for debug and performance.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- ADDR_W, 5, register address width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- Stall  input  1  hold the WB register contents
- Flush  input  1  insert a bubble into WB
- MemValid  input  1  MEM stage holds a real instruction
- MemRegWrite  input  1  the instruction writes a register
- MemWriteAddress  input  ADDR_W  destination register
- MemToReg  input  2  writeback source: 00 ALU, 01 load, 10 link, 11 reserved (treated as ALU)
- MemLoadType  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; others are treated as LW
- MemByteOffset  input  2  address[1:0] of the load
- MemAluResult  input  DATA_W  ALU result
- MemReadData  input  DATA_W  raw data-memory word
- MemLinkPC  input  DATA_W  PC+8 for JAL/JALR
- RegWrite  output  1  register-file write enable
- WriteAddress  output  ADDR_W  register-file write address
- WriteData  output  DATA_W  register-file write data
- WbValid  output  1  WB holds a valid instruction
- InstrRetired  output  32  retired-instruction count

Behaviour:
- rst low (asynchronous, active-low): all WB registers clear immediately, regardless of clk.
  - Outputs: RegWrite 0, WriteAddress 0, WriteData 0, WbValid 0, InstrRetired 0.
- Reset asserted mid-operation discards the in-flight instruction. No write is issued after rst goes low.
- Register update on each posedge, priority Flush > Stall > load:
  - Flush=1: the valid bit clears to 0. Other fields may keep any value.
  - Stall=1 (Flush=0): all fields hold.
  - Otherwise: all Mem* inputs are captured. Latency is exactly 1 cycle from MEM inputs to WB outputs.
- Load extraction is combinational from the registered raw word. Byte order is big-endian:
  - offset 0 selects bits [31:24]; offset 3 selects bits [7:0].
  - Halfword loads use offset[1] only: 0 selects [31:16], 1 selects [15:0]. offset[0] is ignored; there is no misalignment trap.
  - LB and LH sign-extend; LBU and LHU zero-extend. LW passes the word through.
- WriteData mux (combinational from WB registers): ALU result, extracted load data, or link PC, according to the registered MemToReg.
  - WriteData is 0 whenever WbValid is 0.
- RegWrite = valid AND registered MemRegWrite AND (WriteAddress != 0).
  - R0 writes are suppressed here; register_file independently also ignores them.
- WriteAddress always shows the registered address, including when RegWrite is 0.
- WbValid = registered valid bit.
- RegWrite stays asserted for every cycle of a stall. Repeated writes of the same data are harmless.
- InstrRetired:
  - Increments at a posedge when WbValid=1 and Stall=0, so each instruction counts once even when stalled.
  - A bubble does not count. A valid instruction is counted at its leaving edge, including when Flush=1 on that edge.
  - Wraps from 0xFFFFFFFF to 0.
- Simultaneous Flush and Stall: Flush wins, so the bubble enters WB.

Decomposition:
- Shared package mips_pkg holds:
  - MemToReg encodings: WB_SRC_ALU, WB_SRC_MEM, WB_SRC_LINK.
  - Load-type encodings: LD_W, LD_B, LD_BU, LD_H, LD_HU.
- One sub-module, load_extend: combinational; inputs raw word, MemLoadType, MemByteOffset; output extended data. The data-memory store path reuses the same encodings.

Test Plan:
- Reset: drive rst=0 for 3 cycles with MemValid=1 and MemRegWrite=1 -> RegWrite=0, WbValid=0, InstrRetired=0, WriteData=0 throughout. Assert rst mid-cycle -> outputs clear before the next edge.
- ALU writeback: MemValid=1, MemRegWrite=1, addr=5, MemToReg=00, AluResult=0xDEADBEEF -> one cycle later RegWrite=1, WriteAddress=5, WriteData=0xDEADBEEF. Next edge -> InstrRetired=1.
- Loads with ReadData=0x80F27F01:
  - LB offset0 -> 0xFFFFFF80.
  - LBU offset0 -> 0x00000080.
  - LB offset2 -> 0x0000007F.
  - LH offset0 -> 0xFFFF80F2.
  - LHU offset2 -> 0x00007F01.
  - LW -> 0x80F27F01.
- R0 and link: addr=0, AluResult=0xFFFFFFFF -> RegWrite=0 and WbValid=1. JAL with addr=31, MemToReg=10, LinkPC=0x00400008 -> WriteData=0x00400008.
- Stall and flush:
  - Stall=1 for 3 cycles holding addr=10/0x12345678 -> outputs hold and InstrRetired increments once only after release.
  - Flush=1 together with Stall=1 -> WbValid=0 next cycle and RegWrite=0.
- Counter wrap: run 2^32 valid cycles, or force via a bench hierarchical deposit to 0xFFFFFFFF, then one retire -> InstrRetired=0.
